// File: rtl/bm_pkg.sv
// ---------------------------------------------------------------------------
// bm_pkg
// Shared types and widths for the log-unit sharing controller.
//   U_W      : width of a uniform sample fed to the log unit (48)
//   E_W      : width of the signed log result (31)
//   req_id_t : requester index (two requesters)
//   tag_t    : per-issue tag travelling alongside the log unit latency
//              {valid, id[, zero]}. The zero bit only exists when
//              LOG_SHARE_ZERO_FLAG_EN is defined.
// ---------------------------------------------------------------------------
package bm_pkg;

   localparam int U_W = 48;
   localparam int E_W = 31;

   typedef logic [0:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
`ifdef LOG_SHARE_ZERO_FLAG_EN
      logic    zero;
`endif
   } tag_t;

endpackage

// File: rtl/log_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// log_share_ctrl_if
// Bundles the two requester channels, the two result channels and the
// shared log unit operand/result into one interface.
//   master : requesters, result consumers and the log unit itself
//   slave  : the sharing controller (log_share_ctrl)
// Signals:
//   reqN_valid / reqN_u0 / reqN_ready  sample offer and acceptance
//   lg_u0 / lg_e                       operand to and result from log unit
//   rspN_valid / rspN_e / rspN_ready   per-requester result FIFO head
//   rspN_zero                          issued-u0-was-zero flag, only when
//                                      LOG_SHARE_ZERO_FLAG_EN is defined
// ---------------------------------------------------------------------------
interface log_share_ctrl_if;
   import bm_pkg::*;

   logic                  req0_valid;
   logic                  req1_valid;
   logic [U_W-1:0]        req0_u0;
   logic [U_W-1:0]        req1_u0;
   logic                  req0_ready;
   logic                  req1_ready;

   logic [U_W-1:0]        lg_u0;
   logic signed [E_W-1:0] lg_e;

   logic                  rsp0_valid;
   logic                  rsp1_valid;
   logic signed [E_W-1:0] rsp0_e;
   logic signed [E_W-1:0] rsp1_e;
   logic                  rsp0_ready;
   logic                  rsp1_ready;
`ifdef LOG_SHARE_ZERO_FLAG_EN
   logic                  rsp0_zero;
   logic                  rsp1_zero;
`endif

   modport master (
`ifdef LOG_SHARE_ZERO_FLAG_EN
      input  rsp0_zero, rsp1_zero,
`endif
      output req0_valid, req1_valid, req0_u0, req1_u0,
      input  req0_ready, req1_ready,
      input  lg_u0,
      output lg_e,
      input  rsp0_valid, rsp1_valid, rsp0_e, rsp1_e,
      output rsp0_ready, rsp1_ready
   );

   modport slave (
`ifdef LOG_SHARE_ZERO_FLAG_EN
      output rsp0_zero, rsp1_zero,
`endif
      input  req0_valid, req1_valid, req0_u0, req1_u0,
      output req0_ready, req1_ready,
      output lg_u0,
      input  lg_e,
      output rsp0_valid, rsp1_valid, rsp0_e, rsp1_e,
      input  rsp0_ready, rsp1_ready
   );

endinterface

// File: rtl/res_fifo.sv
// ---------------------------------------------------------------------------
// res_fifo
// Small synchronous result FIFO with a combinational head (first-word
// fall-through) so the head is visible in the same cycle valid is high.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (empties the FIFO)
//   i_push      write i_data at the tail
//   i_data      entry to write
//   i_pop       consume the head (ignored when empty)
//   o_data      head entry
//   o_valid     FIFO not empty
//   o_count     number of stored entries
// The upstream credit scheme guarantees no push while full; the assertion
// below guards that contract.
// ---------------------------------------------------------------------------
module res_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 31
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_pop,
   output logic [WIDTH-1:0]        o_data,
   output logic                    o_valid,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full = (r_count == CW'(DEPTH));
   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && !w_full;

   // Storage has no reset so it can map onto plain RAM/LUT memory.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/log_share_ctrl.sv
// ---------------------------------------------------------------------------
// log_share_ctrl
// Shares one pipelined log unit between two requesters. Each cycle at most
// one requester is granted (round-robin on ties); the granted sample is
// registered onto lg_u0, and a {valid, id} tag follows it through LOG_LAT
// stages so that the returning lg_e lands in the right per-requester
// result FIFO. Credits (FIFO space minus results already in flight) make
// FIFO overflow impossible, so no back-pressure to the log unit is needed.
// Parameters:
//   LOG_LAT     cycles from lg_u0 capture edge to lg_e sample edge (1..8)
//   FIFO_DEPTH  per-requester result FIFO depth (power of two, 2..16)
// Ports:
//   clk     single clock, posedge
//   rst_n   synchronous active-low reset
//   io_bus  log_share_ctrl_if.slave (requests, results, log unit)
// Optional feature macro: LOG_SHARE_ZERO_FLAG_EN adds rspN_zero, which
// flags results whose issued u0 was zero.
// ---------------------------------------------------------------------------
module log_share_ctrl
   import bm_pkg::*;
#(
   parameter int LOG_LAT    = 2,
   parameter int FIFO_DEPTH = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   log_share_ctrl_if.slave io_bus
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   // Wide enough to hold FIFO count plus in-flight tags without wrapping.
   localparam int CW  = $clog2(FIFO_DEPTH + LOG_LAT + 1) + 1;
`ifdef LOG_SHARE_ZERO_FLAG_EN
   localparam int DW  = E_W + 1;
`else
   localparam int DW  = E_W;
`endif

   // Per-requester views of the interface
   logic [1:0]     w_req_valid;
   logic [1:0]     w_rsp_ready;
   logic [U_W-1:0] w_req_u0 [2];

   logic [1:0]     w_elig;
   logic [1:0]     w_grant;
   logic [1:0]     w_push;
   logic [1:0]     w_pop;
   logic [1:0]     w_rsp_valid;
   logic [DW-1:0]  w_head [2];
   logic [FCW-1:0] w_count [2];
   logic [CW-1:0]  w_inflight [2];
   logic [DW-1:0]  w_push_data;

   req_id_t        w_gnt_id;
   logic [U_W-1:0] w_sel_u0;
   tag_t           w_new_tag;

   req_id_t        r_prio;
   logic [U_W-1:0] r_lg_u0;
   tag_t           r_tag [LOG_LAT];

   assign w_req_valid = {io_bus.req1_valid, io_bus.req0_valid};
   assign w_rsp_ready = {io_bus.rsp1_ready, io_bus.rsp0_ready};
   assign w_req_u0[0] = io_bus.req0_u0;
   assign w_req_u0[1] = io_bus.req1_u0;

   // Results already committed to the log unit but not yet in a FIFO.
   always_comb begin
      w_inflight[0] = '0;
      w_inflight[1] = '0;
      for (int k = 0; k < LOG_LAT; k++) begin
         if (r_tag[k].valid) begin
            if (r_tag[k].id == 1'b1) begin
               w_inflight[1] = w_inflight[1] + CW'(1);
            end else begin
               w_inflight[0] = w_inflight[0] + CW'(1);
            end
         end
      end
   end

`ifdef LOG_SHARE_ZERO_FLAG_EN
   assign w_push_data = {r_tag[LOG_LAT-1].zero, io_bus.lg_e};
`else
   assign w_push_data = io_bus.lg_e;
`endif

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         // Eligible only with a free credit; a pop in this same cycle is
         // not counted, which keeps the grant path short.
         assign w_elig[gi] = w_req_valid[gi] &&
                             ((CW'(w_count[gi]) + w_inflight[gi]) < CW'(FIFO_DEPTH));

         assign w_push[gi] = r_tag[LOG_LAT-1].valid &&
                             (r_tag[LOG_LAT-1].id == req_id_t'(gi));
         assign w_pop[gi]  = w_rsp_valid[gi] && w_rsp_ready[gi];

         res_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DW)
         ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[gi]),
            .i_data  (w_push_data),
            .i_pop   (w_pop[gi]),
            .o_data  (w_head[gi]),
            .o_valid (w_rsp_valid[gi]),
            .o_count (w_count[gi])
         );
      end
   endgenerate

   // Grant: r_prio names the requester that wins a tie; it always points
   // away from whoever was granted last.
   always_comb begin
      w_grant = 2'b00;
      if (rst_n) begin
         if (&w_elig) begin
            w_grant = (r_prio == 1'b0) ? 2'b01 : 2'b10;
         end else begin
            w_grant = w_elig;
         end
      end
   end

   assign w_gnt_id = w_grant[1];
   assign w_sel_u0 = w_grant[1] ? w_req_u0[1] : w_req_u0[0];

   always_comb begin
      w_new_tag       = '0;
      w_new_tag.valid = |w_grant;
      w_new_tag.id    = w_gnt_id;
`ifdef LOG_SHARE_ZERO_FLAG_EN
      w_new_tag.zero  = (w_sel_u0 == '0);
`endif
   end

   // Tag pipeline mirrors the log unit latency; stage LOG_LAT-1 is valid
   // exactly in the cycle whose closing edge samples the matching lg_e.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prio  <= '0;
         r_lg_u0 <= '0;
         for (int k = 0; k < LOG_LAT; k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         if (|w_grant) begin
            r_prio  <= ~w_gnt_id;
            r_lg_u0 <= w_sel_u0;
         end
         r_tag[0] <= w_new_tag;
         for (int k = 1; k < LOG_LAT; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   assign io_bus.req0_ready = w_grant[0];
   assign io_bus.req1_ready = w_grant[1];
   assign io_bus.lg_u0      = r_lg_u0;
   assign io_bus.rsp0_valid = w_rsp_valid[0];
   assign io_bus.rsp1_valid = w_rsp_valid[1];
   assign io_bus.rsp0_e     = w_head[0][E_W-1:0];
   assign io_bus.rsp1_e     = w_head[1][E_W-1:0];
`ifdef LOG_SHARE_ZERO_FLAG_EN
   assign io_bus.rsp0_zero  = w_head[0][E_W];
   assign io_bus.rsp1_zero  = w_head[1][E_W];
`endif

endmodule

// File: tb/tb_log_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_log_share_ctrl
// Bench for log_share_ctrl. A stand-in log unit returns log_ref(u0)
// LOG_LAT cycles after lg_u0 is captured. A reference model keeps, per
// requester, a queue of issued-but-unconsumed results with their issue
// cycle; from it the expected grants (credit + round-robin) and result
// visibility (age >= LOG_LAT+1) are derived every cycle.
// Optional feature macro: LOG_SHARE_ZERO_FLAG_EN.
// ---------------------------------------------------------------------------
module tb_log_share_ctrl;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   log_share_ctrl_if bus ();

   log_share_ctrl #(
      .LOG_LAT    (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Stand-in log unit: any deterministic function with f(0) = 0.
   function automatic logic [30:0] log_ref(input logic [47:0] u);
      return u[30:0] ^ u[47:17];
   endfunction

   function automatic logic [47:0] rand48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   logic [47:0] hist [8];
   always @(posedge clk) begin
      hist[0] <= bus.lg_u0;
      for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
   end
   assign bus.lg_e = log_ref((LAT == 1) ? bus.lg_u0 : hist[(LAT >= 2) ? LAT - 2 : 0]);

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic [30:0] e;
      logic        z;
      int          cyc;
   } item_t;

   item_t       exp_q [2][$];
   int          last_gnt = 1;   // requester 0 wins the first tie
   bit          mon_en = 1'b0;
   logic [1:0]  m_v, m_rdy, m_rv, m_rr, m_elig, m_gnt;
   logic [47:0] m_u0 [2];
   logic [30:0] m_e [2];
   logic        m_z [2];
   bit          m_exp_v;
   item_t       m_it;

   always @(negedge clk) begin
      if (mon_en) begin
         m_v     = {bus.req1_valid, bus.req0_valid};
         m_rdy   = {bus.req1_ready, bus.req0_ready};
         m_rv    = {bus.rsp1_valid, bus.rsp0_valid};
         m_rr    = {bus.rsp1_ready, bus.rsp0_ready};
         m_u0[0] = bus.req0_u0;
         m_u0[1] = bus.req1_u0;
         m_e[0]  = bus.rsp0_e;
         m_e[1]  = bus.rsp1_e;
         m_z[0]  = 1'b0;
         m_z[1]  = 1'b0;
`ifdef LOG_SHARE_ZERO_FLAG_EN
         m_z[0]  = bus.rsp0_zero;
         m_z[1]  = bus.rsp1_zero;
`endif
         if (!rst_n) begin
            n_tests++;
            if (m_rdy !== 2'b00) begin
               n_fail++;
               $display("FAIL ready_in_reset: got %b expected 00", m_rdy);
            end
            exp_q[0].delete();
            exp_q[1].delete();
            last_gnt = 1;
         end else begin
            for (int n = 0; n < 2; n++) m_elig[n] = m_v[n] && (exp_q[n].size() < DEPTH);
            if (m_elig == 2'b11) m_gnt = (last_gnt == 1) ? 2'b01 : 2'b10;
            else                 m_gnt = m_elig;
            n_tests++;
            if (m_rdy !== m_gnt) begin
               n_fail++;
               $display("FAIL grant @%0d: got %b expected %b", cyc, m_rdy, m_gnt);
            end
            for (int n = 0; n < 2; n++) begin
               m_exp_v = 1'b0;
               if (exp_q[n].size() > 0) m_exp_v = (cyc - exp_q[n][0].cyc) >= (LAT + 1);
               n_tests++;
               if (m_rv[n] !== m_exp_v) begin
                  n_fail++;
                  $display("FAIL rsp%0d_valid @%0d: got %b expected %b", n, cyc, m_rv[n], m_exp_v);
               end
               if (m_exp_v && m_rv[n] === 1'b1) begin
                  m_it = exp_q[n][0];
                  n_tests++;
                  if (m_e[n] !== m_it.e) begin
                     n_fail++;
                     $display("FAIL rsp%0d_e @%0d: got %h expected %h", n, cyc, m_e[n], m_it.e);
                  end
`ifdef LOG_SHARE_ZERO_FLAG_EN
                  n_tests++;
                  if (m_z[n] !== m_it.z) begin
                     n_fail++;
                     $display("FAIL rsp%0d_zero @%0d: got %b expected %b", n, cyc, m_z[n], m_it.z);
                  end
`endif
                  if (m_rr[n] === 1'b1) begin
                     void'(exp_q[n].pop_front());
                     $display("[TB] cyc %0d rsp%0d e=%h z=%b", cyc, n, m_e[n], m_z[n]);
                  end
               end
            end
            // Follow the actual handshakes so one error does not cascade.
            for (int n = 0; n < 2; n++) begin
               if (m_v[n] === 1'b1 && m_rdy[n] === 1'b1) begin
                  m_it.e   = log_ref(m_u0[n]);
                  m_it.z   = (m_u0[n] == 48'd0);
                  m_it.cyc = cyc;
                  exp_q[n].push_back(m_it);
                  last_gnt = n;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers (no checks) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      repeat (n) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      n_tests++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b%b expected 00", bus.req1_ready, bus.req0_ready);
      end
      n_tests++;
      if (bus.lg_u0 !== 48'd0) begin
         n_fail++;
         $display("FAIL reset_lg_u0: got %h expected 0", bus.lg_u0);
      end
      n_tests++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rsp_valid: got %b%b expected 00", bus.rsp1_valid, bus.rsp0_valid);
      end
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_single();
      int lat;
      bit seen;
      logic [47:0] u;
      u = 48'h800000000000;
      tick();
      bus.req0_u0    = u;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: got %b expected 1", bus.req0_ready);
      end
      tick();
      bus.req0_valid = 1'b0;
      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_tests++;
         if (bus.rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp1_quiet: got %b expected 0", bus.rsp1_valid);
         end
         if (!seen && bus.rsp0_valid === 1'b1) begin
            seen = 1'b1;
            lat  = k;
            n_tests++;
            if (bus.rsp0_e !== log_ref(u)) begin
               n_fail++;
               $display("FAIL single_e: got %h expected %h", bus.rsp0_e, log_ref(u));
            end
         end
      end
      n_tests++;
      if (!seen || lat != LAT + 1) begin
         n_fail++;
         $display("FAIL single_latency: got %0d (seen=%0b) expected %0d", lat, seen, LAT + 1);
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      prev = -1;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick();
         bus.req0_valid = 1'b1;
         bus.req1_valid = 1'b1;
         bus.req0_u0    = rand48();
         bus.req1_u0    = rand48();
         @(negedge clk);
         n_tests++;
         if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_onehot: got %b%b expected exactly one", bus.req1_ready, bus.req0_ready);
         end else if (prev >= 0) begin
            n_tests++;
            if (int'(bus.req1_ready) == prev) begin
               n_fail++;
               $display("FAIL b2b_alternate: got %0d expected %0d", bus.req1_ready, 1 - prev);
            end
         end
         prev = int'(bus.req1_ready);
      end
      drain(10);
   endtask

   task automatic test_credit();
      int g;
      bus.rsp0_ready = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1;
      g = 0;
      for (int k = 0; k < 12; k++) begin
         bus.req0_u0 = rand48();
         @(negedge clk);
         if (bus.req0_ready === 1'b1) g++;
         tick();
      end
      n_tests++;
      if (g != DEPTH) begin
         n_fail++;
         $display("FAIL credit_grants: got %0d expected %0d", g, DEPTH);
      end
      @(negedge clk);
      n_tests++;
      if (bus.req0_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL credit_stall: got %b expected 0", bus.req0_ready);
      end
      tick();
      bus.rsp0_ready = 1'b1;
      tick();
      bus.rsp0_ready = 1'b0;
      g = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.req0_ready === 1'b1) g++;
         tick();
      end
      n_tests++;
      if (g != 1) begin
         n_fail++;
         $display("FAIL credit_refill: got %0d expected 1", g);
      end
      drain(12);
   endtask

   task automatic test_reset_midflight();
      tick();
      bus.req0_valid = 1'b1;
      bus.req0_u0    = rand48();
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1;
      bus.req1_u0    = rand48();
      tick();
      bus.req1_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_tests++;
         if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_rsp: got %b%b expected 00", bus.rsp1_valid, bus.rsp0_valid);
         end
         tick();
      end
      @(negedge clk);
      n_tests++;
      if (bus.lg_u0 !== 48'd0) begin
         n_fail++;
         $display("FAIL midreset_lg_u0: got %h expected 0", bus.lg_u0);
      end
   endtask

   task automatic test_push_pop();
      int g;
      bus.rsp0_ready = 1'b0;
      g = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         bus.req0_valid = (g < DEPTH - 1);
         bus.req0_u0    = rand48();
         @(negedge clk);
         if (bus.req0_valid && bus.req0_ready === 1'b1) g++;
      end
      tick();
      bus.req0_valid = 1'b0;
      n_tests++;
      if (g != DEPTH - 1) begin
         n_fail++;
         $display("FAIL pushpop_fill: got %0d expected %0d", g, DEPTH - 1);
      end
      repeat (LAT + 2) tick();
      bus.rsp0_ready = 1'b1;
      bus.req0_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.req0_u0 = rand48();
         @(negedge clk);
         n_tests++;
         if (bus.req0_ready !== 1'b1 || bus.rsp0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_steady @%0d: got rdy=%b vld=%b expected 1 1", k, bus.req0_ready, bus.rsp0_valid);
         end
         tick();
      end
      drain(12);
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         tick();
         bus.req0_valid = ($urandom_range(9) < 7);
         bus.req1_valid = ($urandom_range(9) < 7);
         bus.req0_u0    = ($urandom_range(7) == 0) ? 48'd0 : rand48();
         bus.req1_u0    = ($urandom_range(7) == 0) ? 48'd0 : rand48();
         bus.rsp0_ready = ($urandom_range(9) < 6);
         bus.rsp1_ready = ($urandom_range(9) < 6);
      end
      drain(20);
      @(negedge clk);
      n_tests++;
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
         n_fail++;
         $display("FAIL random_drained: got %0d/%0d left expected 0/0", exp_q[0].size(), exp_q[1].size());
      end
   endtask

`ifdef LOG_SHARE_ZERO_FLAG_EN
   task automatic test_zero_flag();
      bit seen;
      for (int t = 0; t < 2; t++) begin
         tick();
         bus.req1_valid = 1'b1;
         bus.req1_u0    = (t == 0) ? 48'd0 : (rand48() | 48'd1);
         tick();
         bus.req1_valid = 1'b0;
         seen = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!seen && bus.rsp1_valid === 1'b1) begin
               seen = 1'b1;
               n_tests++;
               if (bus.rsp1_zero !== (t == 0)) begin
                  n_fail++;
                  $display("FAIL zero_flag%0d: got %b expected %b", t, bus.rsp1_zero, (t == 0));
               end
               if (t == 0) begin
                  n_tests++;
                  if (bus.rsp1_e !== 31'd0) begin
                     n_fail++;
                     $display("FAIL zero_e: got %h expected 0", bus.rsp1_e);
                  end
               end
            end
            tick();
         end
         n_tests++;
         if (!seen) begin
            n_fail++;
            $display("FAIL zero_seen%0d: got no rsp1_valid expected one", t);
         end
      end
      drain(8);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_u0    = '0;
      bus.req1_u0    = '0;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_credit();
      test_reset_midflight();
      test_push_pop();
      test_random();
`ifdef LOG_SHARE_ZERO_FLAG_EN
      test_zero_flag();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
